// File: rtl/offside_judge_pkg.sv
// Shared constants for the sequential offside judge: FSM encoding and default
// position width used for defender slicing.
package offside_judge_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_DECIDE = 2'd2;

  localparam int POS_W_DFLT = 8;

endpackage

// File: rtl/offside_judge_if.sv
// Request/verdict bundle between the position-capture front end (master) and
// the offside judge (slave).
interface offside_judge_if
  import offside_judge_pkg::*;
#(
  parameter int N_DEF = 4,
  parameter int POS_W = POS_W_DFLT,
  parameter int CNT_W = 8
);

  logic                     start;
  logic [POS_W-1:0]         att;
  logic [POS_W-1:0]         ball;
  logic [N_DEF*POS_W-1:0]   def;
  logic                     clr_cnt;
  logic                     busy;
  logic                     done;
  logic                     p;
  logic [CNT_W-1:0]         off_cnt;

  modport master (
    output start, att, ball, def, clr_cnt,
    input  busy, done, p, off_cnt
  );

  modport slave (
    input  start, att, ball, def, clr_cnt,
    output busy, done, p, off_cnt
  );

endinterface

// File: rtl/offside_top2.sv
// Serial tracker of the two largest values seen; a tie at the top pushes the
// old maximum down, so duplicates occupy both slots.
module offside_top2
  import offside_judge_pkg::*;
#(
  parameter int POS_W = POS_W_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] d,
  input  logic             clear,
  input  logic             en,
  output logic [POS_W-1:0] max1,
  output logic [POS_W-1:0] max2
);

  // NOTE: sequential state uses non-blocking assignments so max2 picks up the
  // pre-edge max1 when both update at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max1 <= '0;
      max2 <= '0;
    end else if (clear) begin
      max1 <= '0;
      max2 <= '0;
    end else if (en) begin
      if (d >= max1) begin
        max2 <= max1;
        max1 <= d;
      end else if (d > max2) begin
        max2 <= d;
      end
    end
  end

endmodule

// File: rtl/offside_judge.sv
// Sequential offside judge: captures one attacker, the ball and N_DEF
// defenders, scans defenders one per cycle, then issues a held verdict.
module offside_judge
  import offside_judge_pkg::*;
#(
  parameter int N_DEF = 4,
  parameter int POS_W = POS_W_DFLT,
  parameter int HALF  = 128,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  offside_judge_if.slave bus
);

  localparam int               IDX_W    = (N_DEF > 1) ? $clog2(N_DEF) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DEF - 1);
  localparam logic [POS_W-1:0] HALF_POS = POS_W'(HALF);

  logic [1:0]             state;
  logic [IDX_W-1:0]       idx;
  logic [POS_W-1:0]       att_q;
  logic [POS_W-1:0]       ball_q;
  logic [N_DEF*POS_W-1:0] def_q;
  logic [POS_W-1:0]       d;
  logic [POS_W-1:0]       max1;
  logic [POS_W-1:0]       max2;
  logic                   accept;
  logic                   scan_en;
  logic                   p_next;
  logic                   p_q;
  logic                   done_q;
  logic [CNT_W-1:0]       cnt_q;

  assign accept  = (state == ST_IDLE) && bus.start;
  assign scan_en = (state == ST_SCAN);
  assign d       = def_q[idx*POS_W +: POS_W];

  // Strict compares throughout: being level with any reference is onside.
  assign p_next = (att_q > max2) && (att_q > ball_q) && (att_q > HALF_POS);

  offside_top2 #(.POS_W(POS_W)) u_top2 (
    .clk   (clk),
    .rst   (rst),
    .d     (d),
    .clear (accept),
    .en    (scan_en),
    .max1  (max1),
    .max2  (max2)
  );

  // NOTE: captured operands are plain registers, not a memory array, so they
  // can take the asynchronous reset like the rest of the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      att_q  <= '0;
      ball_q <= '0;
      def_q  <= '0;
      p_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            att_q  <= bus.att;
            ball_q <= bus.ball;
            def_q  <= bus.def;
            idx    <= '0;
            state  <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          idx <= idx + 1'b1;
          if (idx == IDX_LAST) state <= ST_DECIDE;
        end
        ST_DECIDE: begin
          p_q    <= p_next;
          done_q <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Clear wins over a same-edge increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bus.clr_cnt) begin
      cnt_q <= '0;
    end else if ((state == ST_DECIDE) && p_next && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.busy    = (state != ST_IDLE);
  assign bus.done    = done_q;
  assign bus.p       = p_q;
  assign bus.off_cnt = cnt_q;

endmodule
